vector_alu_sequencer: RTL and testbench
=======================================

VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 The block SHALL have parameters: BITS, default 8, ALU element width; REG_AW, default 2, vector register address width; FIFO_DEPTH, default 4, command queue depth (power of 2, >=2); MULT_CYCLES, default 2, EXEC cycles for multiply (>=1).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept.
- cmd_op  in  3  ALU op: 000 add, 001 sub, 010 mult, 011 cmp, 1xx logic.
- cmd_scalar_sel  in  1  B operand is scalar.
- cmd_scalar  in  BITS  scalar operand.
- cmd_src_a  in  REG_AW  A source register.
- cmd_src_b  in  REG_AW  B source register.
- cmd_dst  in  REG_AW  destination register.
- rf_rd_a_addr  out  REG_AW  register-file read port A address.
- rf_rd_b_addr  out  REG_AW  register-file read port B address.
- alu_op_sel  out  3  to ALU op select.
- alu_scalar_sel  out  1  to ALU scalar select.
- alu_scalar  out  BITS  to ALU scalar.
- alu_en  out  1  ALU result-register capture strobe.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_addr  out  REG_AW  register-file write address.
- busy  out  1  FSM not IDLE or queue not empty.
- done  out  1  one-cycle pulse per retired command.

Function
REQ-004 A command SHALL be accepted on any rising edge with cmd_valid && cmd_ready; cmd_ready SHALL equal !full of the registered queue state (no same-cycle bypass on pop).
REQ-005 The queue SHALL be FIFO order; a command pushed into an empty queue SHALL be poppable no earlier than the next cycle.
REQ-006 The FSM SHALL have states IDLE, FETCH, EXEC and WB.
REQ-007 IDLE->FETCH SHALL occur when the queue is non-empty, popping the head; otherwise the FSM SHALL stay in IDLE.
REQ-008 In FETCH (1 cycle), rf_rd_a_addr/rf_rd_b_addr SHALL present src_a/src_b, and alu_op_sel/alu_scalar_sel/alu_scalar SHALL present the command fields; FETCH->EXEC SHALL be unconditional.
REQ-009 EXEC SHALL last MULT_CYCLES cycles for op 010 and 1 cycle otherwise, using a down-counter; alu_en SHALL be high only in the final EXEC cycle.
REQ-010 In WB (1 cycle), rf_wr_en SHALL be 1, rf_wr_addr SHALL equal dst and done SHALL pulse.
REQ-011 WB->FETCH SHALL occur (popping) if the queue is non-empty; otherwise WB->IDLE.
REQ-012 Per-command latency from FETCH entry to WB SHALL be 2 cycles (non-mult) or MULT_CYCLES+1 (mult); back-to-back throughput SHALL be 1 command per 3 cycles (non-mult).
REQ-013 Read addresses and ALU control outputs SHALL hold their values from FETCH through WB and retain them in IDLE.
REQ-014 alu_en, rf_wr_en and done SHALL be single-cycle pulses and SHALL never be asserted outside EXEC/WB as specified.
REQ-015 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a push while full SHALL be impossible (cmd_ready=0).
REQ-016 Occupancy SHALL be tracked in log2(FIFO_DEPTH)+1 bits; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 busy SHALL be 0 only when the FSM is in IDLE and the queue is empty.

Reset
REQ-018 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the queue SHALL be flushed (cmd_ready=1 the next cycle), the counter SHALL clear, and all outputs SHALL be 0.
REQ-019 Reset mid-command SHALL abort it without asserting rf_wr_en or done.

Structure
REQ-020 The opcode constants (OP_ADD, OP_SUB, OP_MULT, OP_CMP, logic class bit) and the FSM state enum SHALL reside in package vector_alu_pkg.
REQ-021 The queue SHALL be sub-module cmd_fifo, parameterised by width and depth, with synchronous active-low reset.

Verification
REQ-022 The testbench SHALL cover these scenarios:
- Single add, src_a=1, src_b=2, dst=3 pushed at cycle 0: FETCH at cycle 2, alu_en at cycle 3, rf_wr_en with rf_wr_addr=3 and done at cycle 4, busy=0 at cycle 5.
- Mult with MULT_CYCLES=3: alu_en exactly once, 3 cycles after FETCH; WB on the following cycle.
- 5 commands pushed back-to-back with FIFO_DEPTH=4: cmd_ready=0 after 4 pushes until the first pop; all 5 retire in order; done pulses 3 cycles apart.
- Scalar sub, cmd_scalar=8'hA5, cmd_scalar_sel=1: alu_scalar_sel=1 and alu_scalar=8'hA5 stable from FETCH through WB.
- rst_n=0 in EXEC with 2 commands queued: no rf_wr_en or done; next cycle busy=0 and cmd_ready=1; all outputs 0.
- Push during WB with an empty queue: WB->IDLE, then FETCH one cycle later (no bypass).

Source files
------------

// File: rtl/vector_alu_pkg.sv
// Shared opcode constants, FSM state encoding and decode helper for the
// vector ALU sequencer.
package vector_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam int unsigned OP_LOGIC_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic is_mult(input logic [2:0] op);
        return op == OP_MULT;
    endfunction

endpackage

// File: rtl/vector_alu_sequencer_cmd_fifo.sv
// Command queue: synchronous FIFO with occupancy counter, no read-through,
// so a freshly pushed entry becomes visible on the following cycle.
module cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_alu_sequencer.sv
// Sequencer that queues vector ALU commands and steps each one through
// FETCH / EXEC / WB, driving register-file and ALU control strobes.
module vector_alu_sequencer
    import vector_alu_pkg::*;
#(
    parameter int unsigned BITS        = 8,
    parameter int unsigned REG_AW      = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MULT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_scalar_sel,
    input  logic [BITS-1:0]   cmd_scalar,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic [REG_AW-1:0] cmd_dst,
    output logic [REG_AW-1:0] rf_rd_a_addr,
    output logic [REG_AW-1:0] rf_rd_b_addr,
    output logic [2:0]        alu_op_sel,
    output logic              alu_scalar_sel,
    output logic [BITS-1:0]   alu_scalar,
    output logic              alu_en,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CMD_W = 3 + 1 + BITS + 3 * REG_AW;
    localparam int unsigned CW    = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    logic [2:0]        head_op;
    logic              head_ssel;
    logic [BITS-1:0]   head_scalar;
    logic [REG_AW-1:0] head_a;
    logic [REG_AW-1:0] head_b;
    logic [REG_AW-1:0] head_dst;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] cur_dst;

    assign fifo_din = {cmd_op, cmd_scalar_sel, cmd_scalar, cmd_src_a, cmd_src_b, cmd_dst};
    assign {head_op, head_ssel, head_scalar, head_a, head_b, head_dst} = fifo_dout;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = ((state == ST_IDLE) || (state == ST_WB)) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cur_dst        <= '0;
            rf_rd_a_addr   <= '0;
            rf_rd_b_addr   <= '0;
            alu_op_sel     <= '0;
            alu_scalar_sel <= 1'b0;
            alu_scalar     <= '0;
            alu_en         <= 1'b0;
            rf_wr_en       <= 1'b0;
            rf_wr_addr     <= '0;
            done           <= 1'b0;
        end else begin
            alu_en   <= 1'b0;
            rf_wr_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                // Strobes are registered, so each is raised on the edge that
                // enters the cycle it belongs to.
                ST_IDLE, ST_WB: begin
                    if (!fifo_empty) begin
                        state          <= ST_FETCH;
                        rf_rd_a_addr   <= head_a;
                        rf_rd_b_addr   <= head_b;
                        alu_op_sel     <= head_op;
                        alu_scalar_sel <= head_ssel;
                        alu_scalar     <= head_scalar;
                        cur_dst        <= head_dst;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                    if (is_mult(alu_op_sel)) begin
                        cnt    <= CW'(MULT_CYCLES - 1);
                        alu_en <= (MULT_CYCLES == 1);
                    end else begin
                        cnt    <= '0;
                        alu_en <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        state      <= ST_WB;
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= cur_dst;
                        done       <= 1'b1;
                    end else begin
                        cnt    <= cnt - CW'(1);
                        alu_en <= (cnt == CW'(1));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer: directed cycle checks plus a
// write-back scoreboard of {src_a, dst} keyed by accepted commands.
module tb_vector_alu_sequencer;

    localparam int unsigned BITS        = 8;
    localparam int unsigned REG_AW      = 2;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned MULT_CYCLES = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic              cmd_scalar_sel;
    logic [BITS-1:0]   cmd_scalar;
    logic [REG_AW-1:0] cmd_src_a;
    logic [REG_AW-1:0] cmd_src_b;
    logic [REG_AW-1:0] cmd_dst;
    logic [REG_AW-1:0] rf_rd_a_addr;
    logic [REG_AW-1:0] rf_rd_b_addr;
    logic [2:0]        alu_op_sel;
    logic              alu_scalar_sel;
    logic [BITS-1:0]   alu_scalar;
    logic              alu_en;
    logic              rf_wr_en;
    logic [REG_AW-1:0] rf_wr_addr;
    logic              busy;
    logic              done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    logic [2*REG_AW-1:0] sb[$];
    int unsigned         done_at[$];

    vector_alu_sequencer #(
        .BITS        (BITS),
        .REG_AW      (REG_AW),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .MULT_CYCLES (MULT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_scalar_sel (cmd_scalar_sel),
        .cmd_scalar     (cmd_scalar),
        .cmd_src_a      (cmd_src_a),
        .cmd_src_b      (cmd_src_b),
        .cmd_dst        (cmd_dst),
        .rf_rd_a_addr   (rf_rd_a_addr),
        .rf_rd_b_addr   (rf_rd_b_addr),
        .alu_op_sel     (alu_op_sel),
        .alu_scalar_sel (alu_scalar_sel),
        .alu_scalar     (alu_scalar),
        .alu_en         (alu_en),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write-back monitor: every retirement must match the oldest accepted command.
    always @(negedge clk) begin
        if (rst_n && (rf_wr_en || done)) begin
            chk("wb_pair", {30'd0, rf_wr_en, done}, 32'd3);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                chk("wb_order", {28'd0, rf_rd_a_addr, rf_wr_addr}, {28'd0, sb.pop_front()});
            end
        end
        if (rst_n && done) done_at.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic ssel, input logic [BITS-1:0] sc,
                            input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b,
                            input logic [REG_AW-1:0] d);
        bit accepted = 0;
        cmd_op = op; cmd_scalar_sel = ssel; cmd_scalar = sc;
        cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            if (cmd_ready) begin
                sb.push_back({a, d});
                accepted = 1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!accepted) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && busy; i++) tick();
        chk("drain_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        int unsigned en_cnt;
        int unsigned en_at;
        int unsigned wb_at;
        int unsigned nd;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_scalar_sel = 1'b0;
        cmd_scalar = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_outs", {10'd0, rf_rd_a_addr, rf_rd_b_addr, alu_op_sel, alu_scalar_sel,
                         alu_scalar, alu_en, rf_wr_en, rf_wr_addr, busy, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Single add: push at cycle 0, FETCH 2, alu_en 3, WB 4, idle 5.
        push_cmd(3'b000, 1'b0, 8'h00, 2'd1, 2'd2, 2'd3);
        tick();
        chk("add_fetch_a", {30'd0, rf_rd_a_addr}, 32'd1);
        chk("add_fetch_b", {30'd0, rf_rd_b_addr}, 32'd2);
        chk("add_fetch_en", {31'd0, alu_en}, 32'd0);
        tick();
        chk("add_exec_en", {31'd0, alu_en}, 32'd1);
        chk("add_exec_wr", {31'd0, rf_wr_en}, 32'd0);
        tick();
        chk("add_wb_wr", {31'd0, rf_wr_en}, 32'd1);
        chk("add_wb_addr", {30'd0, rf_wr_addr}, 32'd3);
        chk("add_wb_done", {31'd0, done}, 32'd1);
        chk("add_wb_en", {31'd0, alu_en}, 32'd0);
        tick();
        chk("add_idle_busy", {31'd0, busy}, 32'd0);
        chk("add_idle_done", {31'd0, done}, 32'd0);
        wait_idle();

        // Mult with MULT_CYCLES=3: FETCH at 2, alu_en only at 5, WB at 6.
        push_cmd(3'b010, 1'b0, 8'h00, 2'd2, 2'd3, 2'd1);
        tick();
        chk("mul_fetch_op", {29'd0, alu_op_sel}, 32'd2);
        en_cnt = 0; en_at = 0; wb_at = 0;
        for (int k = 2; k < 8; k++) begin
            if (alu_en) begin en_cnt++; en_at = k; end
            if (rf_wr_en) wb_at = k;
            tick();
        end
        chk("mul_en_count", en_cnt, 32'd1);
        chk("mul_en_cycle", en_at, 32'd5);
        chk("mul_wb_cycle", wb_at, 32'd6);
        wait_idle();

        // Scalar sub: scalar controls stable FETCH..WB and retained in IDLE.
        push_cmd(3'b001, 1'b1, 8'hA5, 2'd0, 2'd1, 2'd2);
        tick();
        for (int k = 2; k < 6; k++) begin
            chk("sub_ssel", {31'd0, alu_scalar_sel}, 32'd1);
            chk("sub_scalar", {24'd0, alu_scalar}, 32'hA5);
            chk("sub_op", {29'd0, alu_op_sel}, 32'd1);
            tick();
        end
        wait_idle();

        // Fill: a mult occupies the FSM while four more fill the queue.
        done_at.delete();
        push_cmd(3'b010, 1'b0, 8'h00, 2'd3, 2'd3, 2'd0);
        tick();
        push_cmd(3'b000, 1'b0, 8'h00, 2'd0, 2'd1, 2'd1);
        push_cmd(3'b011, 1'b0, 8'h00, 2'd1, 2'd2, 2'd2);
        push_cmd(3'b100, 1'b0, 8'h00, 2'd2, 2'd3, 2'd3);
        push_cmd(3'b001, 1'b1, 8'h3C, 2'd3, 2'd0, 2'd0);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        push_cmd(3'b101, 1'b0, 8'h00, 2'd0, 2'd2, 2'd3);
        wait_idle();
        chk("fill_retired", 32'(done_at.size()), 32'd6);
        nd = done_at.size();
        if (nd >= 5) begin
            for (int i = nd - 4; i < nd; i++) begin
                chk("done_spacing", done_at[i] - done_at[i-1], 32'd3);
            end
        end

        // Reset during EXEC of a mult with two commands queued behind it.
        push_cmd(3'b010, 1'b1, 8'h5A, 2'd1, 2'd3, 2'd2);
        tick();
        push_cmd(3'b000, 1'b0, 8'h00, 2'd2, 2'd2, 2'd1);
        push_cmd(3'b001, 1'b0, 8'h00, 2'd3, 2'd1, 2'd3);
        chk("abort_pre_wr", {31'd0, rf_wr_en}, 32'd0);
        rst_n = 1'b0;
        sb.delete();
        done_at.delete();
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_outs", {10'd0, rf_rd_a_addr, rf_rd_b_addr, alu_op_sel, alu_scalar_sel,
                           alu_scalar, alu_en, rf_wr_en, rf_wr_addr, busy, done}, 32'd0);
        repeat (10) tick();
        chk("abort_no_done", 32'(done_at.size()), 32'd0);

        // Push during WB with an empty queue: IDLE first, FETCH one cycle later.
        push_cmd(3'b000, 1'b0, 8'h00, 2'd1, 2'd1, 2'd2);
        repeat (3) tick();
        chk("wbpush_wb", {31'd0, rf_wr_en}, 32'd1);
        push_cmd(3'b011, 1'b0, 8'h00, 2'd3, 2'd0, 2'd1);
        chk("wbpush_idle_wr", {31'd0, rf_wr_en}, 32'd0);
        chk("wbpush_idle_busy", {31'd0, busy}, 32'd1);
        chk("wbpush_idle_a", {30'd0, rf_rd_a_addr}, 32'd1);
        tick();
        chk("wbpush_fetch_a", {30'd0, rf_rd_a_addr}, 32'd3);
        chk("wbpush_fetch_op", {29'd0, alu_op_sel}, 32'd3);
        tick();
        chk("wbpush_exec_en", {31'd0, alu_en}, 32'd1);
        wait_idle();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
